// File: rtl/mem_stage_pkg.sv
// Shared width, FSM state encoding and EX/MEM record for the MEM pipeline stage.
// The optional alignment check (MEM_ALIGN_CHECK_EN) uses is_misaligned below.
package mem_stage_pkg;

  localparam int WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] aluout;
    logic [WIDTH-1:0] writedata;
    logic [4:0]       regaddr;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             memtoreg;
  } exmem_t;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic             dmem_req;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register: loads every cycle, either the finished instruction or a bubble.
module memwb_reg
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_bubble,
  input  logic [WIDTH-1:0] aluout_in,
  input  logic [WIDTH-1:0] readdata_in,
  input  logic [4:0]       regaddr_in,
  input  logic             regwrite_in,
  input  logic             memtoreg_in,
  output logic [WIDTH-1:0] aluout_wb,
  output logic [WIDTH-1:0] readdata_wb,
  output logic [4:0]       regaddr_wb,
  output logic             regwrite_wb,
  output logic             memtoreg_wb
);

  // A bubble is fully zeroed so WB sees a clean no-op.
  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      aluout_wb   <= '0;
      readdata_wb <= '0;
      regaddr_wb  <= '0;
      regwrite_wb <= 1'b0;
      memtoreg_wb <= 1'b0;
    end else begin
      aluout_wb   <= aluout_in;
      readdata_wb <= readdata_in;
      regaddr_wb  <= regaddr_in;
      regwrite_wb <= regwrite_in;
      memtoreg_wb <= memtoreg_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, IDLE/BUSY data-memory handshake FSM and MEM/WB register.
// Defining MEM_ALIGN_CHECK_EN adds misalign_mem and suppresses misaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] aluout_exe,
  input  logic [WIDTH-1:0] writedata_exe,
  input  logic [4:0]       regaddr_exe,
  input  logic             memread_exe,
  input  logic             memwrite_exe,
  input  logic             regwrite_exe,
  input  logic             memtoreg_exe,
  mem_stage_if.master      dmem,
  output logic [WIDTH-1:0] aluout_mem,
  output logic [4:0]       regaddr_mem,
  output logic             regwrite_mem,
  output logic [WIDTH-1:0] aluout_wb,
  output logic [WIDTH-1:0] readdata_wb,
  output logic [4:0]       regaddr_wb,
  output logic             regwrite_wb,
  output logic             memtoreg_wb,
  output logic             stall_mem
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic             misalign_mem
`endif
);

  exmem_t     exmem_q;
  exmem_t     exmem_d;
  mem_state_e state_q;
  mem_state_e state_d;
  logic       mem_op;
  logic       misaligned;
  logic       access;
  logic       req;

  always_comb begin
    exmem_d           = '0;
    exmem_d.aluout    = aluout_exe;
    exmem_d.writedata = writedata_exe;
    exmem_d.regaddr   = regaddr_exe;
    exmem_d.memread   = memread_exe;
    exmem_d.memwrite  = memwrite_exe;
    exmem_d.regwrite  = regwrite_exe;
    exmem_d.memtoreg  = memtoreg_exe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_q <= '0;
    end else if (!stall_mem) begin
      exmem_q <= exmem_d;
    end
  end

  assign mem_op = exmem_q.memread | exmem_q.memwrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned   = mem_op & is_misaligned(exmem_q.aluout);
  assign misalign_mem = misaligned;
`else
  assign misaligned   = 1'b0;
`endif

  assign access = mem_op & ~misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A same-cycle ack in IDLE completes without ever visiting BUSY.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          req = 1'b1;
          if (!dmem.dmem_ack) state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        req = 1'b1;
        if (dmem.dmem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_mem       = req & ~dmem.dmem_ack;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = exmem_q.memwrite;
  assign dmem.dmem_addr  = exmem_q.aluout;
  assign dmem.dmem_wdata = exmem_q.writedata;

  assign aluout_mem   = exmem_q.aluout;
  assign regaddr_mem  = exmem_q.regaddr;
  assign regwrite_mem = exmem_q.regwrite;

  // Read data is only meaningful for pure loads; read+write counts as a store.
  memwb_reg u_memwb_reg (
    .clk         (clk),
    .rst         (rst),
    .load_bubble (stall_mem | misaligned),
    .aluout_in   (exmem_q.aluout),
    .readdata_in ((exmem_q.memread && !exmem_q.memwrite) ? dmem.dmem_rdata : '0),
    .regaddr_in  (exmem_q.regaddr),
    .regwrite_in (exmem_q.regwrite),
    .memtoreg_in (exmem_q.memtoreg),
    .aluout_wb   (aluout_wb),
    .readdata_wb (readdata_wb),
    .regaddr_wb  (regaddr_wb),
    .regwrite_wb (regwrite_wb),
    .memtoreg_wb (memtoreg_wb)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, a transaction-level model of the
// stage checked every cycle, and hand-computed expectations for the key scenarios.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] aluout_exe = '0;
  logic [WIDTH-1:0] writedata_exe = '0;
  logic [4:0]       regaddr_exe = '0;
  logic             memread_exe = 1'b0;
  logic             memwrite_exe = 1'b0;
  logic             regwrite_exe = 1'b0;
  logic             memtoreg_exe = 1'b0;
  logic [WIDTH-1:0] aluout_mem;
  logic [4:0]       regaddr_mem;
  logic             regwrite_mem;
  logic [WIDTH-1:0] aluout_wb;
  logic [WIDTH-1:0] readdata_wb;
  logic [4:0]       regaddr_wb;
  logic             regwrite_wb;
  logic             memtoreg_wb;
  logic             stall_mem;
`ifdef MEM_ALIGN_CHECK_EN
  logic             misalign_mem;
`endif

  mem_stage_if dmem_bus ();

  int tests_run = 0;
  int failures  = 0;
  bit check_en  = 1'b0;
  int stall_cnt = 0;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .aluout_exe    (aluout_exe),
    .writedata_exe (writedata_exe),
    .regaddr_exe   (regaddr_exe),
    .memread_exe   (memread_exe),
    .memwrite_exe  (memwrite_exe),
    .regwrite_exe  (regwrite_exe),
    .memtoreg_exe  (memtoreg_exe),
    .dmem          (dmem_bus),
    .aluout_mem    (aluout_mem),
    .regaddr_mem   (regaddr_mem),
    .regwrite_mem  (regwrite_mem),
    .aluout_wb     (aluout_wb),
    .readdata_wb   (readdata_wb),
    .regaddr_wb    (regaddr_wb),
    .regwrite_wb   (regwrite_wb),
    .memtoreg_wb   (memtoreg_wb),
    .stall_mem     (stall_mem)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_mem  (misalign_mem)
`endif
  );

  always #5 clk = ~clk;

  // Model: the instruction sitting in MEM, and what WB is known to hold.
  logic [31:0] m_alu = '0, m_wdata = '0;
  logic [4:0]  m_rd = '0;
  logic        m_mr = 1'b0, m_mw = 1'b0, m_rw = 1'b0, m_m2r = 1'b0;
  bit          w_full = 1'b1, w_read = 1'b0;
  logic [31:0] w_alu = '0, w_rdata = '0;
  logic [4:0]  w_rd = '0;
  logic        w_rw = 1'b0, w_m2r = 1'b0;

  function automatic logic m_mis();
`ifdef MEM_ALIGN_CHECK_EN
    return (m_mr || m_mw) && (m_alu % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_access();
    return (m_mr || m_mw) && !m_mis();
  endfunction

  function automatic logic m_stall();
    return m_access() && !dmem_bus.dmem_ack;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_alu <= '0; m_wdata <= '0; m_rd <= '0;
      m_mr <= 1'b0; m_mw <= 1'b0; m_rw <= 1'b0; m_m2r <= 1'b0;
      w_full <= 1'b1; w_read <= 1'b0; w_alu <= '0; w_rdata <= '0;
      w_rd <= '0; w_rw <= 1'b0; w_m2r <= 1'b0;
    end else begin
      if (m_stall() || m_mis()) begin
        w_full <= 1'b0; w_read <= 1'b0; w_rw <= 1'b0; w_m2r <= 1'b0;
      end else begin
        w_full <= 1'b1; w_read <= m_mr && !m_mw;
        w_alu <= m_alu; w_rdata <= dmem_bus.dmem_rdata;
        w_rd <= m_rd; w_rw <= m_rw; w_m2r <= m_m2r;
      end
      if (!m_stall()) begin
        m_alu <= aluout_exe; m_wdata <= writedata_exe; m_rd <= regaddr_exe;
        m_mr <= memread_exe; m_mw <= memwrite_exe;
        m_rw <= regwrite_exe; m_m2r <= memtoreg_exe;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("m_stall_mem", {31'b0, stall_mem}, {31'b0, m_stall()});
      checkOutput("m_dmem_req", {31'b0, dmem_bus.dmem_req}, {31'b0, m_access()});
      if (m_access()) begin
        checkOutput("m_dmem_addr", dmem_bus.dmem_addr, m_alu);
        checkOutput("m_dmem_wdata", dmem_bus.dmem_wdata, m_wdata);
        checkOutput("m_dmem_we", {31'b0, dmem_bus.dmem_we}, {31'b0, m_mw});
      end
      checkOutput("m_aluout_mem", aluout_mem, m_alu);
      checkOutput("m_regaddr_mem", {27'b0, regaddr_mem}, {27'b0, m_rd});
      checkOutput("m_regwrite_mem", {31'b0, regwrite_mem}, {31'b0, m_rw});
      checkOutput("m_regwrite_wb", {31'b0, regwrite_wb}, {31'b0, w_rw});
      checkOutput("m_memtoreg_wb", {31'b0, memtoreg_wb}, {31'b0, w_m2r});
      if (w_full) begin
        checkOutput("m_aluout_wb", aluout_wb, w_alu);
        checkOutput("m_regaddr_wb", {27'b0, regaddr_wb}, {27'b0, w_rd});
      end
      if (w_read) checkOutput("m_readdata_wb", readdata_wb, w_rdata);
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("m_misalign_mem", {31'b0, misalign_mem}, {31'b0, m_mis()});
`endif
    end
  end

  // Inputs change 1 time unit after the rising edge; returns at the following falling edge.
  task automatic applyStimulus(input logic r, input logic [31:0] alu, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic mr, input logic mw,
                               input logic rw, input logic m2r, input logic ack,
                               input logic [31:0] rdata);
    @(posedge clk);
    #1;
    rst = r; aluout_exe = alu; writedata_exe = wdata; regaddr_exe = rd;
    memread_exe = mr; memwrite_exe = mw; regwrite_exe = rw; memtoreg_exe = m2r;
    dmem_bus.dmem_ack = ack; dmem_bus.dmem_rdata = rdata;
    @(negedge clk);
  endtask

  task automatic nop(input logic ack, input logic [31:0] rdata);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ack, rdata);
  endtask

  initial begin
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;

    applyStimulus(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_en = 1'b1;
    checkOutput("reset_stall", {31'b0, stall_mem}, 32'd0);
    checkOutput("reset_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
    checkOutput("reset_regwrite_wb", {31'b0, regwrite_wb}, 32'd0);
    checkOutput("reset_aluout_wb", aluout_wb, 32'd0);

    // add r5 = 0x10
    applyStimulus(1'b0, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    nop(1'b0, 32'h0);
    checkOutput("add_regaddr_mem", {27'b0, regaddr_mem}, 32'd5);
    checkOutput("add_no_stall", {31'b0, stall_mem}, 32'd0);
    nop(1'b0, 32'h0);
    checkOutput("add_aluout_wb", aluout_wb, 32'h10);
    checkOutput("add_regaddr_wb", {27'b0, regaddr_wb}, 32'd5);
    checkOutput("add_regwrite_wb", {31'b0, regwrite_wb}, 32'd1);

    // lw r6, 0x40 with zero-wait ack
    applyStimulus(1'b0, 32'h40, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    nop(1'b1, 32'hDEADBEEF);
    checkOutput("lw_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
    checkOutput("lw_addr", dmem_bus.dmem_addr, 32'h40);
    checkOutput("lw_no_stall", {31'b0, stall_mem}, 32'd0);
    nop(1'b0, 32'h0);
    checkOutput("lw_readdata_wb", readdata_wb, 32'hDEADBEEF);
    checkOutput("lw_memtoreg_wb", {31'b0, memtoreg_wb}, 32'd1);

    // sw 0x1234 -> 0x44, ack on the fourth request cycle; an add waits behind it
    applyStimulus(1'b0, 32'h44, 32'h1234, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h77, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, (i == 3), 32'h0);
      stall_cnt += int'(stall_mem);
      checkOutput("sw_addr_stable", dmem_bus.dmem_addr, 32'h44);
      checkOutput("sw_wdata_stable", dmem_bus.dmem_wdata, 32'h1234);
      checkOutput("sw_exmem_held", {27'b0, regaddr_mem}, 32'd0);
      checkOutput("sw_wb_bubble", {31'b0, regwrite_wb}, 32'd0);
    end
    checkOutput("sw_stall_cycles", stall_cnt, 32'd3);
    nop(1'b0, 32'h0);
    checkOutput("sw_next_in_mem", {27'b0, regaddr_mem}, 32'd7);
    nop(1'b0, 32'h0);
    checkOutput("sw_next_aluout_wb", aluout_wb, 32'h77);

    // reset while BUSY, then a late ack
    applyStimulus(1'b0, 32'h80, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    nop(1'b0, 32'h0);
    checkOutput("busy_stall", {31'b0, stall_mem}, 32'd1);
    applyStimulus(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nop(1'b1, 32'h99);
    checkOutput("rst_busy_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
    checkOutput("rst_busy_stall", {31'b0, stall_mem}, 32'd0);
    nop(1'b0, 32'h0);
    checkOutput("rst_busy_no_wb", {31'b0, regwrite_wb}, 32'd0);

    // lw r10 followed by dependent add r11, ack after two stall cycles
    applyStimulus(1'b0, 32'h100, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h200, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("dep_stall1", {31'b0, stall_mem}, 32'd1);
    applyStimulus(1'b0, 32'h200, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("dep_stall2", {31'b0, stall_mem}, 32'd1);
    checkOutput("dep_lw_held", {27'b0, regaddr_mem}, 32'd10);
    applyStimulus(1'b0, 32'h200, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D);
    checkOutput("dep_done_no_stall", {31'b0, stall_mem}, 32'd0);
    nop(1'b0, 32'h0);
    checkOutput("dep_add_in_mem", {27'b0, regaddr_mem}, 32'd11);
    checkOutput("dep_lw_readdata", readdata_wb, 32'hCAFEF00D);
    nop(1'b0, 32'h0);
    checkOutput("dep_add_wb", aluout_wb, 32'h200);

    // memread and memwrite both set behaves as a store
    applyStimulus(1'b0, 32'h50, 32'h55, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nop(1'b1, 32'h0);
    checkOutput("rw_both_we", {31'b0, dmem_bus.dmem_we}, 32'd1);

    // back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h1000 + i, 32'h0, 5'(13 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    nop(1'b0, 32'h0);
    nop(1'b0, 32'h0);
    checkOutput("stream_last_wb", aluout_wb, 32'h1003);

    // load from 0x42
    applyStimulus(1'b0, 32'h42, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    nop(1'b0, 32'h0);
    checkOutput("mis_flag", {31'b0, misalign_mem}, 32'd1);
    checkOutput("mis_no_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
    checkOutput("mis_no_stall", {31'b0, stall_mem}, 32'd0);
    nop(1'b0, 32'h0);
    checkOutput("mis_flag_clear", {31'b0, misalign_mem}, 32'd0);
    checkOutput("mis_wb_bubble", {31'b0, regwrite_wb}, 32'd0);
`else
    nop(1'b1, 32'h11223344);
    checkOutput("unaligned_addr", dmem_bus.dmem_addr, 32'h42);
    checkOutput("unaligned_req", {31'b0, dmem_bus.dmem_req}, 32'd1);
    nop(1'b0, 32'h0);
    checkOutput("unaligned_readdata", readdata_wb, 32'h11223344);
`endif
    nop(1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The ports SHALL be: clk, input, 1, rising-edge clock; one clock; reset is synchronous and active-high.
REQ-002 Port: rst, input, 1, synchronous active-high reset.
REQ-003 Inputs from EXE: aluout_exe, input, `WIDTH, ALU result / memory address; writedata_exe, input, `WIDTH, store data; regaddr_exe, input, 5, destination register.
REQ-004 Control inputs: memread_exe, memwrite_exe, regwrite_exe and memtoreg_exe, input, 1 each, EXE-stage control bits.
REQ-005 Data memory request port: dmem_req, output, 1; dmem_we, output, 1; dmem_addr, output, `WIDTH; dmem_wdata, output, `WIDTH.
REQ-006 Data memory response port: dmem_rdata, input, `WIDTH; dmem_ack, input, 1, access complete.
REQ-007 Forwarding outputs to EXE: aluout_mem, output, `WIDTH; regaddr_mem, output, 5; regwrite_mem, output, 1.
REQ-008 WB outputs: aluout_wb and readdata_wb, output, `WIDTH; regaddr_wb, output, 5; regwrite_wb and memtoreg_wb, output, 1.
REQ-009 Hazard output: stall_mem, output, 1; when high, all upstream stages hold.

Function
REQ-010 The EX/MEM register SHALL capture all EXE inputs on each clk edge where stall_mem=0, and SHALL hold when stall_mem=1.
REQ-011 A memory op exists when the EX/MEM register holds memread=1 or memwrite=1; memread and memwrite both set SHALL be treated as a write.
REQ-012 The FSM SHALL have two states, IDLE and BUSY.
REQ-013 In IDLE with a memory op: dmem_req=1; on dmem_ack=1 the op completes that cycle (zero-wait); otherwise the FSM moves to BUSY.
REQ-014 In BUSY: dmem_req stays 1; on dmem_ack=1 the op completes and the FSM returns to IDLE.
REQ-015 While dmem_req=1: dmem_addr=aluout_mem, dmem_wdata=EX/MEM writedata, dmem_we=memwrite, all held stable until ack.
REQ-016 stall_mem SHALL be the combinational value (memory op pending AND NOT dmem_ack).
REQ-017 The MEM/WB register SHALL load aluout, regaddr, regwrite, memtoreg and dmem_rdata (read) on each completing or non-memory cycle.
REQ-018 While stall_mem=1, the MEM/WB register SHALL load a bubble (regwrite_wb=0, memtoreg_wb=0).
REQ-019 dmem_ack received in IDLE with no memory op SHALL be ignored.
REQ-020 Non-memory instructions SHALL flow at one instruction per cycle, with latency from EX/MEM to MEM/WB of one cycle.

Reset
REQ-021 With rst=1 at a clk edge, both pipeline registers SHALL clear to zero, the FSM SHALL go to IDLE, and dmem_req=0 and stall_mem=0 SHALL hold from the next cycle.
REQ-022 Reset during BUSY SHALL abandon the access without a writeback; a late dmem_ack SHALL be ignored per REQ-019.

Configuration
REQ-023 When MEM_ALIGN_CHECK_EN is defined, a memory op with aluout_mem[1:0]!=0 SHALL raise an extra output misalign_mem, output, 1, for one cycle.
REQ-024 With MEM_ALIGN_CHECK_EN defined, a misaligned op SHALL not assert dmem_req, SHALL not stall, and SHALL load a bubble into MEM/WB.
REQ-025 Without MEM_ALIGN_CHECK_EN, the misalign_mem port and the check SHALL be absent, and the low address bits SHALL pass unchanged.

Structure
REQ-026 `WIDTH and the FSM state encoding SHALL reside in the shared defines/package.
REQ-027 The MEM/WB register SHALL be a sub-module named memwb_reg.

Verification
REQ-028 Case: add, aluout_exe=0x10, regaddr=5, regwrite=1 -> aluout_wb=0x10, regaddr_wb=5 two edges later, with no stall.
REQ-029 Case: lw, address 0x40, ack on the first request cycle, rdata=0xDEADBEEF -> readdata_wb=0xDEADBEEF next edge, stall_mem never high.
REQ-030 Case: sw, address 0x44, data 0x1234, ack after 3 cycles -> stall_mem high for 3 cycles, dmem_addr/wdata stable, 3 bubbles in WB, EX/MEM held.
REQ-031 Case: rst asserted in BUSY, then dmem_ack one cycle later -> FSM IDLE, no writeback, dmem_req=0.
REQ-032 Case: with MEM_ALIGN_CHECK_EN defined, lw at 0x42 -> misalign_mem=1 for 1 cycle, dmem_req=0, regwrite_wb=0.
REQ-033 Case: lw followed directly by a dependent add with 2-cycle ack -> upstream held, add enters MEM only after the lw completes.
